bfly_inject_tx: RTL
===================

# bfly_inject_tx

Terminal injection port for the symmetric butterfly network. It takes a routed command and its payload words from the host and serialises them into 18-bit flits for stage-0 `switch_node_4rad` inputs. Output is a contiguous packet: one header flit, then payload flits, then at least two NULL flits. A packet starts only when its whole body is already buffered, so no NULL flit can appear inside a packet.

## Interface
- `MAX_LEN`, 8: maximum payload words per packet; also the depth of the word FIFO.
- `LEN_W`, `$clog2(MAX_LEN+1)`: width of the length field.
- `clk  in  1`: single clock, rising-edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `cmd_valid  in  1`: host command valid.
- `cmd_ready  out  1`: high only in IDLE.
- `cmd_dest  in  16`: route digits, MSB-first; `[15:14]` selects the stage-0 output port.
- `cmd_len  in  LEN_W`: payload word count, `0..MAX_LEN`.
- `wr_valid  in  1`: payload word valid.
- `wr_ready  out  1`: `fifo_count < MAX_LEN`, taken from the registered count.
- `wr_data  in  16`: payload word.
- `out_ch  out  18`: registered flit to the switch.
- `busy  out  1`: state != IDLE.
- `pkt_done  out  1`: one-cycle pulse, registered.
- `err_len  out  1`: sticky, set when an oversized `cmd_len` is captured.

## Operation
- Flit formats:
  - Header = `{2'b11, dest[15:0]}`.
  - Payload = `{2'b10, word}`.
  - NULL = `18'h0`.
  - `out_ch` is NULL in every cycle that is not a header or payload flit.
- Word FIFO:
  - Push on `wr_valid && wr_ready`.
  - Pop only in BODY.
  - Push and pop in the same cycle are allowed; the count is unchanged.
  - Words written for the next packet may arrive while the current body drains.
- FSM states: IDLE, WAIT, BODY, GAP. Transitions per edge:
  - IDLE: on `cmd_valid`, latch `dest` and `len` and go to WAIT. `out_ch <= NULL`.
  - WAIT: if `fifo_count >= len` (registered count, before this edge's push), then `out_ch <= header`, `rem <= len`, and go to BODY if `len != 0`, else GAP. Otherwise stay in WAIT and `out_ch <= NULL`.
  - BODY: `out_ch <= payload(pop)`, `rem <= rem-1`. Go to GAP when `rem == 1`.
  - GAP: `out_ch <= NULL`, `pkt_done <= 1`, go to IDLE. `pkt_done` is 0 on every other edge.
- `cmd_len > MAX_LEN`: store `MAX_LEN` and set `err_len`. `err_len` clears only on reset.
- `cmd_len == 0`: send a header-only packet (header, then the GAP null).

## Timing
- Reset values:
  - State IDLE.
  - FIFO empty, count 0.
  - `out_ch = 18'h0`, `pkt_done = 0`, `err_len = 0`.
  - `busy = 0`, `cmd_ready = 1`, `wr_ready = 1`.
- Reset asserted mid-packet: `out_ch` goes to 0 immediately, the packet is truncated, and the FIFO is flushed. There is no resume.
- Latency, with all words present: command accepted at edge E0, header on `out_ch` after E1, word i after E1+i, NULL after E1+len+1 with `pkt_done` high in that same cycle.
- Back-to-back commands with data ready: exactly two NULL flits between packets (GAP edge, then the IDLE accept edge).
- Payload flits of one packet are always contiguous; WAIT absorbs any data shortfall.
- FIFO full: `wr_ready` is low that cycle, even if a pop occurs on the same edge.

## Structure
- Shared package `bfly_pkg`:
  - `FLIT_W = 18`.
  - Type codes `HDR_TYPE = 2'b11`, `PCK_TYPE = 2'b10`, `NULL_TYPE = 2'b00`.
  - `NULL_FLIT`.
  - `flit_t` typedef.
  - Header/payload pack functions.
  - These are shared with `switch_node_4rad` and its benches.
- Sub-module `bfly_word_fifo`: synchronous FIFO, parameter `DEPTH`, 16-bit data, registered count, async active-low reset.
- Top: FSM, command registers, `rem` counter.

## Test plan
- Single packet: push `DEAD`, `BEEF`; command `dest 16'h0000`, `len 2` -> `out_ch` sequence `{11,0000}`, `{10,DEAD}`, `{10,BEEF}`, `18'h0`; `pkt_done` high on the NULL flit.
- Data starvation: command `dest 16'h4000`, `len 3` with FIFO empty; words arrive 1 per 4 cycles -> NULL until the third word is buffered, then header `{11,4000}` and three consecutive payload flits.
- Back-to-back: two `len 1` commands (`dest 8000` then `C000`) with words `CA7E`, `F00D` preloaded -> header, `CA7E`, NULL, NULL, header `{11,C000}`, `F00D`, NULL.
- Full FIFO: push 8 words with no command -> `wr_ready` drops after the 8th push; command `len 8` -> 8 payload flits in order, and `wr_ready` rises one cycle after the first pop.
- Illegal length and zero length: `cmd_len 9` -> 8 payload flits and `err_len = 1`, which stays set; then `cmd_len 0`, `dest 16'h1234` -> `{11,1234}` followed by NULL.
- Reset mid-body: assert `rst_n = 0` after the 2nd payload flit of a `len 4` packet -> `out_ch = 0` immediately and FIFO count 0; after release, `cmd_ready = 1`.

Source files
------------

// File: rtl/bfly_pkg.sv
// bfly_pkg: flit types, codes and pack helpers shared by the butterfly injection port and switch nodes
package bfly_pkg;
  localparam int FLIT_W = 18;
  localparam logic [1:0] HDR_TYPE  = 2'b11;
  localparam logic [1:0] PCK_TYPE  = 2'b10;
  localparam logic [1:0] NULL_TYPE = 2'b00;
  typedef logic [FLIT_W-1:0] flit_t;
  localparam flit_t NULL_FLIT = {NULL_TYPE, 16'h0000};
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_BODY, ST_GAP} tx_state_t;
  function automatic flit_t hdr_flit(input logic [15:0] dest);
    return {HDR_TYPE, dest};
  endfunction
  function automatic flit_t pay_flit(input logic [15:0] word);
    return {PCK_TYPE, word};
  endfunction
endpackage

// File: rtl/bfly_word_fifo.sv
// bfly_word_fifo: 16-bit sync FIFO (push/wdata in, pop/rdata out, registered count), caller guarantees no overflow/underflow
module bfly_word_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1),
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [15:0]      wdata,
  input  logic             pop,
  output logic [15:0]      rdata,
  output logic [CNT_W-1:0] count
);
  logic [15:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    wr_d = push ? ((wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d = pop ? ((rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= wdata;
  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/bfly_inject_tx.sv
// bfly_inject_tx: serialises host command (cmd_*) plus payload words (wr_*) into header/payload/NULL flits on out_ch
module bfly_inject_tx import bfly_pkg::*; #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [15:0]      cmd_dest,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [15:0]      wr_data,
  output logic [17:0]      out_ch,
  output logic             busy,
  output logic             pkt_done,
  output logic             err_len
);
  tx_state_t state_q, state_d;
  logic [15:0] dest_q, dest_d;
  logic [LEN_W-1:0] len_q, len_d, rem_q, rem_d;
  flit_t out_q, out_d;
  logic done_q, done_d, err_q, err_d;
  logic [LEN_W-1:0] fifo_count;
  logic [15:0] fifo_rdata;
  logic push, pop, oversize;
  assign wr_ready = fifo_count < LEN_W'(MAX_LEN);
  assign push = wr_valid && wr_ready;
  assign pop = state_q == ST_BODY;
  assign oversize = cmd_len > LEN_W'(MAX_LEN);
  bfly_word_fifo #(.DEPTH(MAX_LEN), .CNT_W(LEN_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wr_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );
  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    len_d   = len_q;
    rem_d   = rem_q;
    out_d   = NULL_FLIT;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: if (cmd_valid) begin
        state_d = ST_WAIT;
        dest_d  = cmd_dest;
        len_d   = oversize ? LEN_W'(MAX_LEN) : cmd_len;
        err_d   = err_q | oversize;
      end
      ST_WAIT: if (fifo_count >= len_q) begin
        out_d   = hdr_flit(dest_q);
        rem_d   = len_q;
        state_d = (len_q != '0) ? ST_BODY : ST_GAP;
      end
      ST_BODY: begin
        out_d   = pay_flit(fifo_rdata);
        rem_d   = rem_q - 1'b1;
        state_d = (rem_q == LEN_W'(1)) ? ST_GAP : ST_BODY;
      end
      default: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dest_q  <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      out_q   <= NULL_FLIT;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  assign out_ch    = out_q;
  assign pkt_done  = done_q;
  assign err_len   = err_q;
  assign busy      = state_q != ST_IDLE;
  assign cmd_ready = state_q == ST_IDLE;
endmodule
